data_mem_arbiter: RTL and testbench

//  Shares DATA_MEM_CHANNELS data-memory channels among all per-thread LSU requesters in the gpu.

---
 rtl/gpu_mem_pkg.sv | 18 +
 rtl/mem_rr_picker.sv | 33 +++
 rtl/data_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the data-memory channel arbiter.
// Holds the channel state encoding, the read-over-write policy and a modular increment.
package gpu_mem_pkg;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} mem_chan_state_t;

    localparam bit READ_FIRST = 1'b1;

    function automatic int wrap_inc(input int base, input int step, input int n);
        int sum;
        sum = base + step;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin picker: first set bit of i_mask scanning upward from i_start, wrapping.
// Produces a one-hot pick, the picked index and a found flag.
module mem_rr_picker
    import gpu_mem_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_pick,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_pick  = '0;
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'(wrap_inc(int'(i_start), k, N));
            if (!o_found && i_mask[w_cand]) begin
                o_found        = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU requesters.
// Each channel runs IDLE -> READ_WAIT/WRITE_WAIT -> RELAY -> IDLE with address/data latched at grant.
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    mem_chan_state_t                          r_state [NUM_CHANNELS];
    mem_chan_state_t                          w_state_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][IW-1:0]          r_cons;
    logic [NUM_CHANNELS-1:0]                  r_is_rd;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   r_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   r_wdata;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   r_rdata;
    logic [NUM_CONSUMERS-1:0]                 r_owned;
    logic [IW-1:0]                            r_rr_ptr;

    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] w_mask;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] w_pick;
    logic [NUM_CHANNELS-1:0]                    w_found;
    logic [NUM_CHANNELS-1:0][IW-1:0]            w_idx;
    logic [NUM_CHANNELS-1:0]                    w_take_rd;
    logic [NUM_CHANNELS-1:0]                    w_cons_valid;
    logic [NUM_CONSUMERS-1:0]                   w_release;
    logic [NUM_CONSUMERS-1:0]                   w_grant_all;
    logic                                       w_any_grant;
    logic [IW-1:0]                              w_last;
    logic [IW-1:0]                              w_rr_next;

    // Picker chain: each channel sees the eligible mask minus what lower channels took this cycle.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pick
        if (gi == 0) begin : g_head
            assign w_mask[gi] = (consumer_read_valid | consumer_write_valid) & ~r_owned;
        end else begin : g_link
            assign w_mask[gi] = w_mask[gi-1] & ~w_pick[gi-1];
        end

        mem_rr_picker #(
            .N  (NUM_CONSUMERS),
            .IW (IW)
        ) u_picker (
            .i_mask  (w_mask[gi] & {NUM_CONSUMERS{r_state[gi] == IDLE}}),
            .i_start (r_rr_ptr),
            .o_pick  (w_pick[gi]),
            .o_found (w_found[gi]),
            .o_idx   (w_idx[gi])
        );

        assign mem_read_valid[gi]    = (r_state[gi] == READ_WAIT);
        assign mem_write_valid[gi]   = (r_state[gi] == WRITE_WAIT);
        assign mem_read_address[gi]  = r_addr[gi];
        assign mem_write_address[gi] = r_addr[gi];
        assign mem_write_data[gi]    = r_wdata[gi];
    end

    assign w_rr_next = IW'(wrap_inc(int'(w_last), 1, NUM_CONSUMERS));

    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        w_release            = '0;
        w_grant_all          = '0;
        w_any_grant          = 1'b0;
        w_last               = '0;
        w_take_rd            = '0;
        w_cons_valid         = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_state_next[c] = r_state[c];
            w_take_rd[c]    = READ_FIRST ? consumer_read_valid[w_idx[c]]
                                         : !consumer_write_valid[w_idx[c]];
            w_cons_valid[c] = r_is_rd[c] ? consumer_read_valid[r_cons[c]]
                                         : consumer_write_valid[r_cons[c]];
            case (r_state[c])
                IDLE:       if (w_found[c]) w_state_next[c] = w_take_rd[c] ? READ_WAIT : WRITE_WAIT;
                READ_WAIT:  if (mem_read_ready[c]) w_state_next[c] = RELAY;
                WRITE_WAIT: if (mem_write_ready[c]) w_state_next[c] = RELAY;
                RELAY:      if (!w_cons_valid[c]) w_state_next[c] = IDLE;
                default:    w_state_next[c] = IDLE;
            endcase
            if (r_state[c] == RELAY) begin
                if (r_is_rd[c]) begin
                    consumer_read_ready[r_cons[c]] = 1'b1;
                    consumer_read_data[r_cons[c]]  = r_rdata[c];
                end else begin
                    consumer_write_ready[r_cons[c]] = 1'b1;
                end
                if (!w_cons_valid[c]) begin
                    w_release[r_cons[c]] = 1'b1;
                end
            end
            // Highest granting channel holds the furthest consumer in scan order.
            if (w_found[c]) begin
                w_any_grant = 1'b1;
                w_last      = w_idx[c];
            end
            w_grant_all = w_grant_all | w_pick[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= IDLE;
            end
            r_cons   <= '0;
            r_is_rd  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_owned  <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= w_state_next[c];
                if (w_found[c]) begin
                    r_cons[c]  <= w_idx[c];
                    r_is_rd[c] <= w_take_rd[c];
                    r_addr[c]  <= w_take_rd[c] ? consumer_read_address[w_idx[c]]
                                               : consumer_write_address[w_idx[c]];
                    r_wdata[c] <= consumer_write_data[w_idx[c]];
                end
                if (r_state[c] == READ_WAIT && mem_read_ready[c]) begin
                    r_rdata[c] <= mem_read_data[c];
                end
            end
            r_owned <= (r_owned & ~w_release) | w_grant_all;
            if (w_any_grant) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a behavioural memory with adjustable latency answers the
// channels while one initial block walks through read, write, abandon, reset, fairness and matadd.
module tb_data_mem_arbiter;

    localparam int N = 16;
    localparam int C = 4;

    logic                clk;
    logic                reset;
    logic [N-1:0]        consumer_read_valid;
    logic [N-1:0][7:0]   consumer_read_address;
    logic [N-1:0]        consumer_read_ready;
    logic [N-1:0][7:0]   consumer_read_data;
    logic [N-1:0]        consumer_write_valid;
    logic [N-1:0][7:0]   consumer_write_address;
    logic [N-1:0][7:0]   consumer_write_data;
    logic [N-1:0]        consumer_write_ready;
    logic [C-1:0]        mem_read_valid;
    logic [C-1:0][7:0]   mem_read_address;
    logic [C-1:0]        mem_read_ready;
    logic [C-1:0][7:0]   mem_read_data;
    logic [C-1:0]        mem_write_valid;
    logic [C-1:0][7:0]   mem_write_address;
    logic [C-1:0][7:0]   mem_write_data;
    logic [C-1:0]        mem_write_ready;

    logic [7:0] mem [256];
    int         mem_lat;
    int         rcnt [C];
    int         wcnt [C];

    int n_checks;
    int n_pass;
    int n_fail;

    data_mem_arbiter #(
        .ADDR_BITS     (8),
        .DATA_BITS     (8),
        .NUM_CONSUMERS (N),
        .NUM_CHANNELS  (C)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ready rises once a request has been seen for mem_lat cycles.
    initial begin
        mem_read_ready  = '0;
        mem_read_data   = '0;
        mem_write_ready = '0;
        for (int c = 0; c < C; c++) begin
            rcnt[c] = 0;
            wcnt[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < C; c++) begin
                if (!mem_read_valid[c]) begin
                    rcnt[c] = 0;
                    mem_read_ready[c] = 1'b0;
                end else if (!mem_read_ready[c]) begin
                    rcnt[c] = rcnt[c] + 1;
                    if (rcnt[c] >= mem_lat) begin
                        mem_read_ready[c] = 1'b1;
                        mem_read_data[c]  = mem[mem_read_address[c]];
                    end
                end
                if (!mem_write_valid[c]) begin
                    wcnt[c] = 0;
                    mem_write_ready[c] = 1'b0;
                end else if (!mem_write_ready[c]) begin
                    wcnt[c] = wcnt[c] + 1;
                    if (wcnt[c] >= mem_lat) begin
                        mem_write_ready[c] = 1'b1;
                        mem[mem_write_address[c]] = mem_write_data[c];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          rounds;
    int          relays;
    int          base;
    int          done;
    int          phase [8];
    logic [7:0]  op_a [8];
    logic [7:0]  op_b [8];
    logic [31:0] exp_addr;
    logic [15:0] exp_mask;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        mem_lat  = 1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset                  = 1'b0;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;

        // Reset state
        step();
        step();
        check("rst_crd_ready", consumer_read_ready, 0);
        check("rst_cwr_ready", consumer_write_ready, 0);
        check("rst_mrd_valid", mem_read_valid, 0);
        check("rst_mwr_valid", mem_write_valid, 0);
        check("rst_mrd_addr", mem_read_address, 0);
        reset = 1'b1;
        step();

        // Single read: consumer 3, addr 05 -> 2A, memory latency 1
        mem[8'h05] = 8'h2A;
        consumer_read_address[3] = 8'h05;
        consumer_read_valid[3]   = 1'b1;
        step();
        check("rd_mem_valid", mem_read_valid, 4'b0001);
        check("rd_mem_addr0", mem_read_address[0], 8'h05);
        check("rd_not_yet", consumer_read_ready, 0);
        step();
        check("rd_ready", consumer_read_ready, 16'h0008);
        check("rd_data", consumer_read_data[3], 8'h2A);
        consumer_read_valid[3] = 1'b0;
        $display("txn read  consumer=3 addr=05 data=%0h", consumer_read_data[3]);
        step();
        check("rd_released", consumer_read_ready, 0);

        // Single write: consumer 0 writes 11 to 10
        consumer_write_address[0] = 8'h10;
        consumer_write_data[0]    = 8'h11;
        consumer_write_valid[0]   = 1'b1;
        step();
        check("wr_mem_valid", mem_write_valid, 4'b0001);
        check("wr_mem_addr0", mem_write_address[0], 8'h10);
        check("wr_mem_data0", mem_write_data[0], 8'h11);
        step();
        check("wr_ready", consumer_write_ready, 16'h0001);
        check("wr_mem_word", mem[8'h10], 8'h11);
        consumer_write_valid[0] = 1'b0;
        $display("txn write consumer=0 addr=10 data=11");
        step();

        // Abandon: consumer 2 drops valid while its read is outstanding
        mem[8'h22] = 8'h5C;
        mem[8'h23] = 8'h77;
        mem_lat = 3;
        consumer_read_address[2] = 8'h22;
        consumer_read_valid[2]   = 1'b1;
        step();
        check("ab_mem_addr", mem_read_address[0], 8'h22);
        step();
        consumer_read_valid[2] = 1'b0;
        step();
        check("ab_wait", consumer_read_ready, 0);
        step();
        check("ab_pulse", consumer_read_ready, 16'h0004);
        mem_lat = 1;
        step();
        check("ab_pulse_end", consumer_read_ready, 0);
        consumer_read_address[2] = 8'h23;
        consumer_read_valid[2]   = 1'b1;
        step();
        check("ab_regrant", mem_read_valid[0], 1'b1);
        check("ab_regrant_addr", mem_read_address[0], 8'h23);
        step();
        check("ab_data", consumer_read_data[2], 8'h77);
        consumer_read_valid[2] = 1'b0;
        $display("txn read  consumer=2 addr=23 data=%0h (after abandon)", consumer_read_data[2]);
        step();

        // Reset asserted while a write waits on memory
        mem_lat = 5;
        consumer_write_address[7] = 8'h37;
        consumer_write_data[7]    = 8'h99;
        consumer_write_valid[7]   = 1'b1;
        step();
        check("rs_wr_valid", mem_write_valid, 4'b0001);
        step();
        reset = 1'b0;
        #1;
        check("rs_async_drop", mem_write_valid, 0);
        check("rs_async_addr", mem_write_address, 0);
        consumer_write_valid[7] = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("rs_after", mem_write_valid, 0);
        check("rs_abandoned", mem[8'h37], 8'h00);
        $display("txn write consumer=7 addr=37 abandoned by reset");

        // Fairness: all 16 consumers read continuously, rr_ptr starts at 0
        mem_lat = 1;
        for (int n = 0; n < N; n++) begin
            mem[n] = 8'(n) ^ 8'hA5;
            consumer_read_address[n] = 8'(n);
        end
        consumer_read_valid = '1;
        rounds = 0;
        relays = 0;
        for (int cyc = 0; cyc < 80 && (rounds < 8 || relays < 8); cyc++) begin
            step();
            if (mem_read_valid == 4'hF) begin
                for (int c = 0; c < C; c++) exp_addr[c*8 +: 8] = 8'((rounds * 4 + c) % N);
                check("fair_grant", mem_read_address, exp_addr);
                rounds++;
            end
            if (consumer_read_ready != 0) begin
                base     = 4 * (relays % 4);
                exp_mask = 16'hF << base;
                check("fair_relay", consumer_read_ready, exp_mask);
                check("fair_data", consumer_read_data[base], 8'(base) ^ 8'hA5);
                $display("txn fair  round=%0d ready=%04h", relays, consumer_read_ready);
                relays++;
            end
            consumer_read_valid = ~consumer_read_ready;
        end
        consumer_read_valid = '0;
        check("fair_rounds", rounds, 8);
        step();
        step();

        // Matadd: thread i loads A[i], B[i] and stores the sum at 16+i
        for (int i = 0; i < 8; i++) begin
            mem[i]      = 8'(i);
            mem[8 + i]  = 8'(i);
            mem[16 + i] = 8'hFF;
            phase[i]    = 0;
            op_a[i]     = 8'h00;
            op_b[i]     = 8'h00;
        end
        done = 0;
        for (int cyc = 0; cyc < 300 && done < 8; cyc++) begin
            step();
            for (int i = 0; i < 8; i++) begin
                if (phase[i] < 2) begin
                    if (consumer_read_ready[i]) begin
                        if (phase[i] == 0) op_a[i] = consumer_read_data[i];
                        else               op_b[i] = consumer_read_data[i];
                        consumer_read_valid[i] = 1'b0;
                        phase[i] = phase[i] + 1;
                    end else begin
                        consumer_read_valid[i]   = 1'b1;
                        consumer_read_address[i] = (phase[i] == 0) ? 8'(i) : 8'(8 + i);
                    end
                end else if (phase[i] == 2) begin
                    if (consumer_write_ready[i]) begin
                        consumer_write_valid[i] = 1'b0;
                        phase[i] = 3;
                        done++;
                        $display("txn store thread=%0d addr=%0d data=%0d", i, 16 + i, op_a[i] + op_b[i]);
                    end else begin
                        consumer_write_valid[i]   = 1'b1;
                        consumer_write_address[i] = 8'(16 + i);
                        consumer_write_data[i]    = op_a[i] + op_b[i];
                    end
                end
            end
        end
        check("mat_done", done, 8);
        for (int i = 0; i < 8; i++) begin
            check("mat_result", mem[16 + i], 8'(2 * i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
